imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
// - Instruction-memory responder: the memory end of the CPU fetch interface.
// - The CPU presents a byte PC and a request. This block returns the 32-bit
//   instruction word with a valid pulse.
// - A host-side load port fills the word-addressed RAM before or between runs.
// - Sits between the CPU core's fetch stage and the program loader.
// PARAMETERS
// - ADDR_W  9              word-address bits; depth = 2**ADDR_W words
// - DATA_W  32             instruction width
// - NOP     32'h00000013   word driven on reset and on a fetch error (ADDI x0,x0,0)
// PORTS
// - clk          in   1         system clock, rising edge
// - rst          in   1         asynchronous, active-high reset
// - fetch_req    in   1         fetch request; held with fetch_pc until fetch_valid
// - fetch_pc     in   32        byte address of the requested instruction
// - instruction  out  DATA_W    returned word (registered)
// - fetch_valid  out  1         one-cycle pulse: instruction/fetch_err are valid
// - fetch_err    out  1         PC misaligned or out of range (valid with fetch_valid)
// - load_en      in   1         host write strobe
// - load_addr    in   ADDR_W    host word address
// - load_data    in   DATA_W    host write data
// - load_ready   out  1         write accepted on an edge where load_en && load_ready
// - loaded_count out  ADDR_W+1  accepted host writes since reset; saturates at 2**ADDR_W
// BEHAVIOUR
// - Reset values (asynchronous, immediate): state=IDLE, instruction=NOP,
//   fetch_valid=0, fetch_err=0, load_ready=1, loaded_count=0. RAM contents NOT cleared.
// - FSM states: IDLE, READ, RESP, LOAD.
//   - IDLE, load_en=1: write at this edge, go to LOAD. Load wins over a simultaneous
//     fetch_req; the fetch is not queued, so the requester keeps it held.
//   - IDLE, fetch_req=1 and load_en=0: decode the PC, issue the sync RAM read
//     (or flag an error), go to READ.
//   - READ: on the next edge go to RESP. At that same edge, register instruction
//     (RAM data, or NOP on error), fetch_err, and fetch_valid=1.
//   - RESP: fetch_valid is high for exactly this cycle; fetch_req is ignored.
//     Next edge: go to IDLE and drop fetch_valid.
//   - LOAD: each edge with load_en=1 writes one word. load_en=0 returns to IDLE.
// - Latency and throughput: fetch_req sampled at edge k makes fetch_valid high in
//   the cycle after edge k+1. Back-to-back throughput is 1 fetch per 3 cycles.
// - PC decode:
//   - word index = fetch_pc[ADDR_W+1:2]
//   - fetch_err=1 if fetch_pc[1:0] != 0 or fetch_pc[31:ADDR_W+2] != 0
//   - an errored fetch does no RAM read and keeps the same latency
// - Load port rules:
//   - load_ready = 0 in READ and RESP, so no write can collide with a pending read
//   - a write to address A followed by a fetch of A returns the new data
//   - instruction holds its last value between responses
// - loaded_count increments by 1 per accepted write and stops at 2**ADDR_W.
//   Rewriting an address still counts.
// - Reset mid-READ/RESP aborts the response: no fetch_valid, state IDLE.
//   Reset mid-LOAD: an edge coinciding with rst does not write.
// STRUCTURE
// - Package imem_pkg: typedef enum logic [1:0] {IDLE, READ, RESP, LOAD} imem_state_t;
//   localparam NOP_INSTR = 32'h00000013.
// - Sub-module imem_ram: single-port RAM, synchronous read and write, 1 port,
//   parameters ADDR_W/DATA_W, no reset. Top level holds the FSM, decode,
//   output registers and counter.
// TESTING
// 1. Reset: assert rst mid-cycle -> outputs go immediately to instruction=32'h00000013,
//    fetch_valid=0, load_ready=1, loaded_count=0.
// 2. Load addr0=32'h02268193, addr1=32'h0C600E93 -> loaded_count=2.
//    Fetch pc=0 -> valid 2 edges later with 32'h02268193, err=0.
//    Fetch pc=4 -> 32'h0C600E93.
// 3. Fetch pc=32'h6 -> fetch_err=1, instruction=NOP.
//    Fetch pc=32'h800 (ADDR_W=9) -> fetch_err=1.
//    Both have the same 2-edge latency.
// 4. Same edge: load_en, load_addr=2, data 32'h04CF4A13, and fetch_req with pc=8 ->
//    write first, LOAD for one cycle, then the held fetch returns 32'h04CF4A13.
// 5. load_en asserted during READ -> load_ready=0 in READ/RESP, no write.
//    Write lands on the first edge back in IDLE; loaded_count +1 only then.
// 6. rst pulse during READ of pc=0 -> no fetch_valid.
//    After release, fetch pc=0 -> 32'h02268193 (RAM retained).
//    Also cover: 2**ADDR_W+3 writes -> loaded_count saturates at 512.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {IDLE, READ, RESP, LOAD} imem_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/imem_ram.sv
// Single-port instruction RAM: synchronous write and synchronous read, no reset.
module imem_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Read data is only updated on a read, so it stays stable through READ.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Memory end of the CPU fetch interface: PC decode, sync RAM read, registered
// response, plus a host load port that fills the RAM between fetches.
module imem_responder import imem_pkg::*; #(
    parameter int                 ADDR_W = 9,
    parameter int                 DATA_W = 32,
    parameter logic [DATA_W-1:0]  NOP    = NOP_INSTR
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_req,
    input  logic [31:0]       i_fetch_pc,
    output logic [DATA_W-1:0] o_instruction,
    output logic              o_fetch_valid,
    output logic              o_fetch_err,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_load_ready,
    output logic [ADDR_W:0]   o_loaded_count
);

    // state | meaning
    // IDLE  | accept a load (priority) or a fetch
    // READ  | RAM read in flight; response registered at the next edge
    // RESP  | fetch_valid high for this single cycle
    // LOAD  | host streaming writes, one per edge while load_en

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    imem_state_t       r_state;
    imem_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_instruction;
    logic              r_fetch_valid;
    logic              r_fetch_err;
    logic              r_err_pend;
    logic [ADDR_W:0]   r_loaded_count;

    logic              w_pc_err;
    logic [ADDR_W-1:0] w_pc_idx;
    logic              w_load_ready;
    logic              w_load_fire;
    logic              w_fetch_start;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;

    always_comb begin
        w_pc_idx      = i_fetch_pc[ADDR_W+1:2];
        w_pc_err      = (i_fetch_pc[1:0] != 2'b00) || (i_fetch_pc[31:ADDR_W+2] != '0);
        w_load_ready  = (r_state == IDLE) || (r_state == LOAD);
        // An edge that coincides with reset must not disturb the RAM.
        w_load_fire   = i_load_en && w_load_ready && !i_rst;
        w_fetch_start = (r_state == IDLE) && !i_load_en && i_fetch_req;
        w_ram_we      = w_load_fire;
        w_ram_re      = w_fetch_start && !w_pc_err && !i_rst;
        w_ram_addr    = w_ram_we ? i_load_addr : w_pc_idx;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_load_en) begin
                    w_state_nxt = LOAD;
                end else if (i_fetch_req) begin
                    w_state_nxt = READ;
                end
            end
            READ:    w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            LOAD: begin
                if (!i_load_en) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_instruction  <= NOP;
            r_fetch_valid  <= 1'b0;
            r_fetch_err    <= 1'b0;
            r_err_pend     <= 1'b0;
            r_loaded_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_valid <= 1'b0;
            if (w_fetch_start) begin
                r_err_pend <= w_pc_err;
            end
            if (r_state == READ) begin
                r_instruction <= r_err_pend ? NOP : w_ram_rdata;
                r_fetch_err   <= r_err_pend;
                r_fetch_valid <= 1'b1;
            end
            if (w_load_fire && (r_loaded_count != DEPTH)) begin
                r_loaded_count <= r_loaded_count + 1'b1;
            end
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (i_load_data),
        .o_rdata (w_ram_rdata)
    );

    assign o_instruction  = r_instruction;
    assign o_fetch_valid  = r_fetch_valid;
    assign o_fetch_err    = r_fetch_err;
    assign o_load_ready   = w_load_ready;
    assign o_loaded_count = r_loaded_count;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized
// load/fetch traffic against an array-based memory model.
module tb_imem_responder;

    localparam int          DEPTH = 512;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        load_en = 1'b0;
    logic [8:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic [31:0] instruction;
    logic        fetch_valid;
    logic        fetch_err;
    logic        load_ready;
    logic [9:0]  loaded_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_written [DEPTH];
    int          model_count = 0;

    imem_responder dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_fetch_req    (fetch_req),
        .i_fetch_pc     (fetch_pc),
        .o_instruction  (instruction),
        .o_fetch_valid  (fetch_valid),
        .o_fetch_err    (fetch_err),
        .i_load_en      (load_en),
        .i_load_addr    (load_addr),
        .i_load_data    (load_data),
        .o_load_ready   (load_ready),
        .o_loaded_count (loaded_count)
    );

    always #5 clk = ~clk;

    function automatic void model_write(input int addr, input logic [31:0] data);
        model_mem[addr]     = data;
        model_written[addr] = 1'b1;
        model_count         = (model_count < DEPTH) ? model_count + 1 : DEPTH;
    endfunction

    function automatic bit exp_err(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc >= 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return exp_err(pc) ? NOP : model_mem[pc / 4];
    endfunction

    // All tasks are entered at a falling edge with the DUT in IDLE.
    task automatic do_write(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = 9'(addr);
        load_data = data;
        @(negedge clk);
        model_write(addr, data);
        load_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_fetch(input logic [31:0] pc, output logic [31:0] instr,
                            output logic err, output int lat, output logic drop_ok);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        lat       = -1;
        instr     = 'x;
        err       = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (fetch_valid) begin
                lat   = n;
                instr = instruction;
                err   = fetch_err;
                break;
            end
        end
        fetch_req = 1'b0;
        @(negedge clk);
        drop_ok = !fetch_valid;
    endtask

    task automatic test_reset();
        logic [31:0] ins;
        logic        err, drop;
        int          lat;
        do_write(5, 32'h12345678);
        do_fetch(32'd20, ins, err, lat, drop);
        checks++;
        if (instruction !== 32'h12345678) begin
            failures++;
            $display("FAIL reset_pre_instr: got %h expected %h", instruction, 32'h12345678);
        end
        #2 rst = 1'b1;
        model_count = 0;
        #1;
        checks++;
        if (instruction !== NOP || fetch_valid !== 1'b0 || load_ready !== 1'b1 ||
            loaded_count !== 10'd0) begin
            failures++;
            $display("FAIL reset_values: got instr=%h valid=%b ready=%b count=%0d expected %h 0 1 0",
                     instruction, fetch_valid, load_ready, loaded_count, NOP);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_fetch();
        logic [31:0] ins;
        logic        err, drop;
        int          lat;
        do_write(0, 32'h02268193);
        do_write(1, 32'h0C600E93);
        checks++;
        if (loaded_count !== 10'(model_count)) begin
            failures++;
            $display("FAIL load_count: got %0d expected %0d", loaded_count, model_count);
        end
        for (int i = 0; i < 2; i++) begin
            do_fetch(32'(4 * i), ins, err, lat, drop);
            checks++;
            if (lat !== 2 || ins !== model_mem[i] || err !== 1'b0 || drop !== 1'b1) begin
                failures++;
                $display("FAIL fetch_word%0d: got lat=%0d instr=%h err=%b drop=%b expected 2 %h 0 1",
                         i, lat, ins, err, drop, model_mem[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] pcs [2];
        logic [31:0] ins;
        logic        err, drop;
        int          lat;
        pcs[0] = 32'h6;
        pcs[1] = 32'h800;
        for (int i = 0; i < 2; i++) begin
            do_fetch(pcs[i], ins, err, lat, drop);
            checks++;
            if (lat !== 2 || ins !== NOP || err !== 1'b1) begin
                failures++;
                $display("FAIL fetch_err pc=%h: got lat=%0d instr=%h err=%b expected 2 %h 1",
                         pcs[i], lat, ins, err, NOP);
            end
        end
    endtask

    task automatic test_collision();
        int lat = -1;
        logic [31:0] ins = 'x;
        logic err = 1'bx;
        load_en   = 1'b1;
        load_addr = 9'd2;
        load_data = 32'h04CF4A13;
        fetch_req = 1'b1;
        fetch_pc  = 32'h8;
        @(negedge clk);
        model_write(2, 32'h04CF4A13);
        checks++;
        if (load_ready !== 1'b1 || fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL collision_load_state: got ready=%b valid=%b expected 1 0", load_ready, fetch_valid);
        end
        load_en = 1'b0;
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (fetch_valid) begin
                lat = n;
                ins = instruction;
                err = fetch_err;
                break;
            end
        end
        fetch_req = 1'b0;
        @(negedge clk);
        checks++;
        if (lat !== 4 || ins !== 32'h04CF4A13 || err !== 1'b0) begin
            failures++;
            $display("FAIL collision_fetch: got lat=%0d instr=%h err=%b expected 4 %h 0",
                     lat, ins, err, 32'h04CF4A13);
        end
    endtask

    task automatic test_load_during_read();
        logic [31:0] ins;
        logic        err, drop;
        int          lat;
        int          c0;
        fetch_req = 1'b1;
        fetch_pc  = 32'h0;
        @(negedge clk);
        c0        = model_count;
        load_en   = 1'b1;
        load_addr = 9'd7;
        load_data = 32'hCAFE0007;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_read: got %b expected 0", load_ready);
        end
        @(negedge clk);
        checks++;
        if (fetch_valid !== 1'b1 || instruction !== model_mem[0] || load_ready !== 1'b0 ||
            loaded_count !== 10'(c0)) begin
            failures++;
            $display("FAIL resp_under_load: got valid=%b instr=%h ready=%b count=%0d expected 1 %h 0 %0d",
                     fetch_valid, instruction, load_ready, loaded_count, model_mem[0], c0);
        end
        fetch_req = 1'b0;
        @(negedge clk);
        checks++;
        if (loaded_count !== 10'(c0) || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_before_write: got count=%0d ready=%b expected %0d 1", loaded_count, load_ready, c0);
        end
        @(negedge clk);
        model_write(7, 32'hCAFE0007);
        checks++;
        if (loaded_count !== 10'(model_count)) begin
            failures++;
            $display("FAIL deferred_write_count: got %0d expected %0d", loaded_count, model_count);
        end
        load_en = 1'b0;
        @(negedge clk);
        do_fetch(32'd28, ins, err, lat, drop);
        checks++;
        if (ins !== 32'hCAFE0007 || err !== 1'b0 || lat !== 2) begin
            failures++;
            $display("FAIL deferred_write_data: got instr=%h err=%b lat=%0d expected %h 0 2", ins, err, lat, 32'hCAFE0007);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] vec = '0;
        fetch_req = 1'b1;
        fetch_pc  = 32'h4;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            vec[i] = fetch_valid;
            if (fetch_valid) begin
                checks++;
                if (instruction !== model_mem[1]) begin
                    failures++;
                    $display("FAIL b2b_data: got %h expected %h", instruction, model_mem[1]);
                end
            end
        end
        fetch_req = 1'b0;
        checks++;
        if (vec !== 9'b010010010) begin
            failures++;
            $display("FAIL b2b_pattern: got %b expected %b", vec, 9'b010010010);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] ins;
        logic        err, drop;
        int          lat;
        bit          seen = 1'b0;
        fetch_req = 1'b1;
        fetch_pc  = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        model_count = 0;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || load_ready !== 1'b1 || loaded_count !== 10'd0) begin
            failures++;
            $display("FAIL rst_in_read: got valid=%b ready=%b count=%0d expected 0 1 0",
                     fetch_valid, load_ready, loaded_count);
        end
        @(negedge clk);
        rst       = 1'b0;
        fetch_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (fetch_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rst_aborts_resp: got valid seen=%b expected 0", seen);
        end
        do_fetch(32'h0, ins, err, lat, drop);
        checks++;
        if (ins !== 32'h02268193 || err !== 1'b0 || lat !== 2) begin
            failures++;
            $display("FAIL ram_retained: got instr=%h err=%b lat=%0d expected %h 0 2", ins, err, lat, 32'h02268193);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins, pc;
        logic        err, drop;
        int          lat, a;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_write(int'($urandom_range(0, 15)), $urandom);
                checks++;
                if (loaded_count !== 10'(model_count)) begin
                    failures++;
                    $display("FAIL rand_count it=%0d: got %0d expected %0d", it, loaded_count, model_count);
                end
            end else begin
                case ($urandom_range(0, 3))
                    0: pc = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
                    1: begin
                        pc = $urandom;
                        if (pc < 32'h800) pc = pc | 32'h8000_0000;
                    end
                    default: begin
                        a = int'($urandom_range(0, 15));
                        if (!model_written[a]) do_write(a, $urandom);
                        pc = 32'(4 * a);
                    end
                endcase
                do_fetch(pc, ins, err, lat, drop);
                checks++;
                if (lat !== 2 || err !== exp_err(pc) || ins !== exp_instr(pc) || drop !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_fetch pc=%h: got lat=%0d err=%b instr=%h drop=%b expected 2 %b %h 1",
                             pc, lat, err, ins, drop, exp_err(pc), exp_instr(pc));
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] ins;
        logic        err, drop;
        int          lat;
        #1 rst = 1'b1;
        model_count = 0;
        #1 rst = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            load_en   = 1'b1;
            load_addr = 9'(i % DEPTH);
            load_data = 32'(i) ^ 32'hA5A5_0000;
            model_write(i % DEPTH, 32'(i) ^ 32'hA5A5_0000);
            @(negedge clk);
            if (i == DEPTH - 2 || i == DEPTH - 1) begin
                checks++;
                if (loaded_count !== 10'(model_count)) begin
                    failures++;
                    $display("FAIL sat_boundary i=%0d: got %0d expected %0d", i, loaded_count, model_count);
                end
            end
        end
        load_en = 1'b0;
        @(negedge clk);
        checks++;
        if (loaded_count !== 10'(model_count) || model_count != DEPTH) begin
            failures++;
            $display("FAIL sat_final: got %0d expected %0d", loaded_count, DEPTH);
        end
        do_fetch(32'h8, ins, err, lat, drop);
        checks++;
        if (ins !== model_mem[2] || err !== 1'b0) begin
            failures++;
            $display("FAIL sat_rewrite_data: got %h err=%b expected %h 0", ins, err, model_mem[2]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_fetch();
        test_errors();
        test_collision();
        test_load_during_read();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
